// File: rtl/fp_addsub_arbiter_if.sv
// Request, core-side and response signals of the shared FP add/sub arbiter.
// The slave modport is the arbiter; the master modport is the client/core side.
interface fp_addsub_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int EXC_CNT_W = 16
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;

    logic [31:0]           core_a;
    logic [31:0]           core_b;
    logic                  core_sub;
    logic [31:0]           core_result;
    logic                  core_exception;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_exception;

    logic                  busy;
    logic [EXC_CNT_W-1:0]  exc_count;

    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        input  core_result, core_exception,
        input  rsp_ready,
        output req_ready,
        output core_a, core_b, core_sub,
        output rsp_valid, rsp_id, rsp_result, rsp_exception,
        output busy, exc_count
    );

    modport master (
        output req_valid, req_a, req_b, req_sub,
        output core_result, core_exception,
        output rsp_ready,
        input  req_ready,
        input  core_a, core_b, core_sub,
        input  rsp_valid, rsp_id, rsp_result, rsp_exception,
        input  busy, exc_count
    );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one external
// combinational FP add/sub core among NUM_REQ requesters.
module fp_addsub_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int EXC_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fp_addsub_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_id;
    logic [31:0]          r_core_a;
    logic [31:0]          r_core_b;
    logic                 r_core_sub;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [31:0]          r_rsp_result;
    logic                 r_rsp_exception;
    logic [EXC_CNT_W-1:0] r_exc_count;

    logic                 w_window;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_rsp_fire;
    logic [ID_W-1:0]      w_win;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]   w_ready;

    // A new op may only be taken while idle or while the pending response leaves this cycle.
    assign w_window   = ~rst & ((r_state == S_IDLE) | ((r_state == S_RESP) & bus.rsp_ready));
    assign w_accept   = w_window & w_found;
    assign w_rsp_fire = r_rsp_valid & bus.rsp_ready;
    assign w_ptr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(k);
            if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_accept && (w_win == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_result    <= '0;
            r_rsp_exception <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_valid     <= 1'b1;
                    r_rsp_result    <= bus.core_result;
                    r_rsp_exception <= bus.core_exception;
                    r_rsp_id        <= r_id;
                    r_state         <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_accept ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand registers only move on an acceptance so the core input stays quiet otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_a   <= '0;
            r_core_b   <= '0;
            r_core_sub <= 1'b0;
            r_id       <= '0;
            r_ptr      <= '0;
        end else if (w_accept) begin
            r_core_a   <= bus.req_a[32*w_win +: 32];
            r_core_b   <= bus.req_b[32*w_win +: 32];
            r_core_sub <= bus.req_sub[w_win];
            r_id       <= w_win;
            r_ptr      <= w_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_count <= '0;
        end else if (w_rsp_fire && r_rsp_exception && !(&r_exc_count)) begin
            r_exc_count <= r_exc_count + 1'b1;
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.core_a        = r_core_a;
    assign bus.core_b        = r_core_b;
    assign bus.core_sub      = r_core_sub;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_rsp_id;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_exception = r_rsp_exception;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.exc_count     = r_exc_count;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Scoreboard bench for fp_addsub_arbiter: directed ops are queued with their
// hand-computed results and a negedge monitor checks each delivered response.
module tb_fp_addsub_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int EXC_CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nErrors = 0;

    fp_addsub_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .EXC_CNT_W(EXC_CNT_W)) bus ();

    fp_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .EXC_CNT_W(EXC_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
        logic            exc;
    } rspT;

    rspT sbQ[$];

    // Stand-in for the external core: a table of the directed operand triples.
    function automatic logic [32:0] coreModel(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] r;
        case ({a, b, sub})
            {32'h3F800000, 32'h40000000, 1'b0}: r = {1'b0, 32'h40400000};
            {32'h40400000, 32'h3F800000, 1'b1}: r = {1'b0, 32'h40000000};
            {32'h3F800000, 32'h3F800000, 1'b0}: r = {1'b0, 32'h40000000};
            {32'h40000000, 32'h40000000, 1'b0}: r = {1'b0, 32'h40800000};
            {32'h40800000, 32'h3F800000, 1'b1}: r = {1'b0, 32'h40400000};
            {32'h3F800000, 32'h3F000000, 1'b0}: r = {1'b0, 32'h3FC00000};
            {32'h7F800000, 32'h3F800000, 1'b0}: r = {1'b1, 32'h00000000};
            default:                            r = {1'b0, 32'hDEADBEEF};
        endcase
        return r;
    endfunction

    logic [32:0] coreOut;
    assign coreOut            = coreModel(bus.core_a, bus.core_b, bus.core_sub);
    assign bus.core_result    = coreOut[31:0];
    assign bus.core_exception = coreOut[32];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL unexpected_rsp: got id %0d result 0x%08h, expected no response",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                rspT e;
                e = sbQ.pop_front();
                checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                checkOutput("rsp_result", bus.rsp_result, e.result);
                checkOutput("rsp_exception", 32'(bus.rsp_exception), 32'(e.exc));
            end
        end
    end

    task automatic waitGrant(input int id);
        bit got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready[id]) got = 1'b1;
        end
        nChecks++;
        if (!got) begin
            nErrors++;
            $display("[TB] FAIL grant_timeout: requester %0d got no req_ready, expected a grant", id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (!bus.busy && sbQ.size() == 0) ok = 1'b1;
        end
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("[TB] FAIL idle_timeout: busy=%0d pending=%0d, expected idle with no pending", bus.busy, sbQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
        bus.req_sub[id]        = sub;
    endtask

    task automatic pushExp(input int id, input logic [31:0] res, input logic exc);
        rspT e;
        e.id     = ID_W'(id);
        e.result = res;
        e.exc    = exc;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input logic [31:0] expRes, input logic expExc, input bit expectRsp);
        setOp(id, a, b, sub);
        bus.req_valid[id] = 1'b1;
        if (expectRsp) pushExp(id, expRes, expExc);
        waitGrant(id);
        bus.req_valid[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        setOp(0, 32'h3F800000, 32'h40000000, 1'b0);
        bus.req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset_exc_count", 32'(bus.exc_count), 32'h0);
        checkOutput("reset_core_a", bus.core_a, 32'h0);
        checkOutput("reset_rsp_result", bus.rsp_result, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst           = 1'b0;

        // Single add: grant in cycle 0, response in cycle 2.
        bus.rsp_ready = 1'b1;
        setOp(0, 32'h3F800000, 32'h40000000, 1'b0);
        bus.req_valid[0] = 1'b1;
        pushExp(0, 32'h40400000, 1'b0);
        @(negedge clk);
        checkOutput("t1_grant_cycle0", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("t1_busy_exec", 32'(bus.busy), 32'h1);
        checkOutput("t1_core_a", bus.core_a, 32'h3F800000);
        checkOutput("t1_core_b", bus.core_b, 32'h40000000);
        checkOutput("t1_rsp_valid_cycle1", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("t1_rsp_valid_cycle2", 32'(bus.rsp_valid), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t1_back_to_idle", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;

        // Subtract from requester 2; pointer now at 1 so 2 wins over 0.
        setOp(2, 32'h40400000, 32'h3F800000, 1'b1);
        setOp(0, 32'h3F800000, 32'h3F000000, 1'b0);
        bus.req_valid = 4'b0101;
        pushExp(2, 32'h40000000, 1'b0);
        pushExp(0, 32'h3FC00000, 1'b0);
        @(negedge clk);
        checkOutput("t2_grant_after_ptr1", 32'(bus.req_ready), 32'h4);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        waitGrant(0);
        bus.req_valid[0] = 1'b0;
        waitIdle();

        // Fairness: reset pointer, all four requesters continuously valid.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        setOp(0, 32'h3F800000, 32'h3F800000, 1'b0);
        setOp(1, 32'h40000000, 32'h40000000, 1'b0);
        setOp(2, 32'h40800000, 32'h3F800000, 1'b1);
        setOp(3, 32'h3F800000, 32'h3F000000, 1'b0);
        pushExp(0, 32'h40000000, 1'b0);
        pushExp(1, 32'h40800000, 1'b0);
        pushExp(2, 32'h40400000, 1'b0);
        pushExp(3, 32'h3FC00000, 1'b0);
        pushExp(0, 32'h40000000, 1'b0);
        bus.req_valid = 4'b1111;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            checkOutput("t3_ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'h1);
            if (cyc % 2 == 0)
                checkOutput("t3_grant_order", 32'(bus.req_ready), 32'h1 << ((cyc / 2) % 4));
            else
                checkOutput("t3_no_grant_exec", 32'(bus.req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        waitIdle();

        // Back-pressure: response held for 5 cycles, then requester 1 taken on release.
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b1);
        setOp(1, 32'h40000000, 32'h40000000, 1'b0);
        bus.req_valid[1] = 1'b1;
        pushExp(1, 32'h40800000, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid", 32'(bus.rsp_valid), 32'h1);
            checkOutput("t4_hold_result", bus.rsp_result, 32'h40400000);
            checkOutput("t4_hold_id", 32'(bus.rsp_id), 32'h0);
            checkOutput("t4_no_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_same_cycle_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("t4_exec_no_valid", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("t4_rsp_two_later", 32'(bus.rsp_valid), 32'h1);
        checkOutput("t4_rsp_id", 32'(bus.rsp_id), 32'h1);
        @(posedge clk);
        #1;
        waitIdle();

        // Exception path and counter saturation at 2 bits.
        for (int n = 1; n <= 5; n++) begin
            applyStimulus(3, 32'h7F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 1'b1);
            waitIdle();
            checkOutput("t5_exc_count", 32'(bus.exc_count), (n < 3) ? n : 3);
        end

        // Reset while in EXEC drops the operation.
        applyStimulus(2, 32'h40800000, 32'h3F800000, 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t6_in_exec", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy_cleared", 32'(bus.busy), 32'h0);
        checkOutput("t6_rsp_valid_cleared", 32'(bus.rsp_valid), 32'h0);
        checkOutput("t6_exc_count_cleared", 32'(bus.exc_count), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t6_no_dropped_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        setOp(0, 32'h3F800000, 32'h3F800000, 1'b0);
        setOp(3, 32'h3F800000, 32'h3F000000, 1'b0);
        bus.req_valid = 4'b1001;
        pushExp(0, 32'h40000000, 1'b0);
        pushExp(3, 32'h3FC00000, 1'b0);
        @(negedge clk);
        checkOutput("t6_ptr_reset_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        waitGrant(3);
        bus.req_valid[3] = 1'b0;
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
